// File: rtl/aes_dec_arbiter_pkg.sv
// Shared types and constants for the AES decryption-core arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package aes_dec_arbiter_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int TIMEOUT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    START,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/aes_dec_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr+1 (mod N_REQ).
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module aes_dec_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant,
  output logic             any
);

  logic [ID_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid index is the last one written
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one AES-128 decryption core between N_REQ requesters, one job at a time, round-robin.
// Latency: accept pulse -> resp_valid = 3 + core latency; TIMEOUT cycles in WAIT aborts with resp_err.
// Backpressure: response held until resp_ready; no new grant while a response is pending.
module aes_dec_arbiter
  import aes_dec_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*AES_BLOCK_W-1:0] req_text,
  input  logic [N_REQ*AES_BLOCK_W-1:0] req_key,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [AES_BLOCK_W-1:0]       resp_text,
  output logic                         resp_err,
  output logic                         core_reset,
  output logic                         core_decrypt,
  output logic [AES_BLOCK_W-1:0]       core_text,
  output logic [AES_BLOCK_W-1:0]       core_key,
  input  logic                         core_done,
  input  logic [AES_BLOCK_W-1:0]       core_dout
);

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]       req_ready_d;
  logic                   resp_valid_d, resp_err_d;
  logic [ID_W-1:0]        resp_id_d;
  logic [AES_BLOCK_W-1:0] resp_text_d, core_text_d, core_key_d;
  logic                   core_reset_d, core_decrypt_d;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic                   timed_out;

  aes_dec_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign timed_out = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

  // State and all registered outputs; reset parks the core in reset with req 0 next in line
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(N_REQ - 1);
      cnt_q        <= '0;
      req_ready    <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_text    <= '0;
      resp_err     <= 1'b0;
      core_reset   <= 1'b1;
      core_decrypt <= 1'b0;
      core_text    <= '0;
      core_key     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      req_ready    <= req_ready_d;
      resp_valid   <= resp_valid_d;
      resp_id      <= resp_id_d;
      resp_text    <= resp_text_d;
      resp_err     <= resp_err_d;
      core_reset   <= core_reset_d;
      core_decrypt <= core_decrypt_d;
      core_text    <= core_text_d;
      core_key     <= core_key_d;
    end
  end

  // Next-state: one job walks IDLE -> CLR -> START -> WAIT -> RESP and back
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = CLR;
      CLR:     state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (core_done || timed_out) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next output values; core_done is looked at only in WAIT because it may be stale from the last job
  always_comb begin
    req_ready_d    = '0;
    resp_valid_d   = resp_valid;
    resp_id_d      = resp_id;
    resp_text_d    = resp_text;
    resp_err_d     = resp_err;
    core_reset_d   = core_reset;
    core_decrypt_d = 1'b0;
    core_text_d    = core_text;
    core_key_d     = core_key;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    case (state_q)
      IDLE: begin
        core_reset_d = 1'b1;
        if (pick_any) begin
          req_ready_d = N_REQ'(1) << pick_idx;
          core_text_d = req_text[pick_idx*AES_BLOCK_W +: AES_BLOCK_W];
          core_key_d  = req_key[pick_idx*AES_BLOCK_W +: AES_BLOCK_W];
          resp_id_d   = pick_idx;
          ptr_d       = pick_idx;
        end
      end
      CLR: begin
        core_reset_d   = 1'b0;
        core_decrypt_d = 1'b1;
      end
      START: cnt_d = '0;
      WAIT: begin
        if (core_done) begin
          resp_text_d  = core_dout;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          core_reset_d = 1'b1;
        end else if (timed_out) begin
          resp_text_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          core_reset_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (resp_ready) resp_valid_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_dec_arbiter.sv
module tb_aes_dec_arbiter;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 63;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*128-1:0]   req_text = '0;
  logic [N_REQ*128-1:0]   req_key = '0;
  logic                   resp_valid;
  logic                   resp_ready = 1'b0;
  logic [ID_W-1:0]        resp_id;
  logic [127:0]           resp_text;
  logic                   resp_err;
  logic                   core_reset;
  logic                   core_decrypt;
  logic [127:0]           core_text;
  logic [127:0]           core_key;
  logic                   core_done;
  logic [127:0]           core_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 42;
  bit stuck    = 1'b0;
  bit sticky   = 1'b0;
  int cnt_core;
  int exp_ptr  = N_REQ - 1;
  int t_acc    = 0;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [127:0]    text;
    logic            err;
    int              lat;
  } exp_t;
  exp_t sb[$];

  aes_dec_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_text(req_text), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_text(resp_text), .resp_err(resp_err),
    .core_reset(core_reset), .core_decrypt(core_decrypt), .core_text(core_text),
    .core_key(core_key), .core_done(core_done), .core_dout(core_dout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Stand-in decryption core: the C.1 vector decrypts properly, other inputs use a simple keyed mix
  function automatic logic [127:0] model_pt(input logic [127:0] t, input logic [127:0] k);
    if (t == CT && k == KEY) return PT;
    return t ^ {k[63:0], k[127:64]};
  endfunction

  // Core model: done appears lat cycles after the decrypt-pulse cycle; sticky mode keeps done through reset
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_core  <= 0;
      core_done <= 1'b0;
      core_dout <= '0;
    end else if (core_reset && !sticky) begin
      cnt_core  <= 0;
      core_done <= 1'b0;
    end else if (core_decrypt) begin
      cnt_core  <= lat;
      core_done <= 1'b0;
    end else if (cnt_core != 0) begin
      cnt_core <= cnt_core - 1;
      if (cnt_core == 1 && !stuck) begin
        core_done <= 1'b1;
        core_dout <= model_pt(core_text, core_key);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A response and an accept pulse must never coexist
  always @(negedge clock) begin
    if (reset_n) begin
      n_checks++;
      assert (!(resp_valid && (req_ready != '0))) else begin
        n_fail++;
        $error("FAIL resp_and_ready: observed resp_valid=%b req_ready=%b expected no overlap",
               resp_valid, req_ready);
      end
    end
  end

  task automatic set_req(input int i, input logic [127:0] t, input logic [127:0] k);
    req_text[128*i +: 128] = t;
    req_key[128*i +: 128]  = k;
    req_valid[i]           = 1'b1;
  endtask

  task automatic expect_grant(input bit drop);
    int n;
    int eg;
    logic [N_REQ-1:0] v;
    logic [127:0] t, k;
    exp_t e;
    v  = req_valid;
    eg = 0;
    for (int j = N_REQ; j >= 1; j--) if (v[(exp_ptr + j) % N_REQ]) eg = (exp_ptr + j) % N_REQ;
    n = 0;
    while (req_ready == '0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("grant", {124'b0, req_ready}, {124'b0, N_REQ'(1) << eg});
    t = req_text[128*eg +: 128];
    k = req_key[128*eg +: 128];
    check("core_text", core_text, t);
    check("core_key", core_key, k);
    t_acc = cyc;
    e.id  = ID_W'(eg);
    if (stuck || lat > TIMEOUT - 1) begin
      e.text = '0;
      e.err  = 1'b1;
      e.lat  = TIMEOUT + 2;
    end else begin
      e.text = model_pt(t, k);
      e.err  = 1'b0;
      e.lat  = lat + 3;
    end
    sb.push_back(e);
    exp_ptr = eg;
    if (drop) req_valid[eg] = 1'b0;
  endtask

  task automatic expect_resp(input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!resp_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("resp_valid", {127'b0, resp_valid}, 128'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 128'd0, 128'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 128'(cyc - t_acc), 128'(e.lat));
    check("resp_id", {126'b0, resp_id}, {126'b0, e.id});
    check("resp_text", resp_text, e.text);
    check("resp_err", {127'b0, resp_err}, {127'b0, e.err});
    check("core_reset_resp", {127'b0, core_reset}, 128'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", {127'b0, resp_valid}, 128'd1);
      check("hold_text", resp_text, e.text);
      check("hold_id", {126'b0, resp_id}, {126'b0, e.id});
      check("hold_no_grant", {124'b0, req_ready}, 128'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("resp_drop", {127'b0, resp_valid}, 128'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, {124'b0, req_ready}, 128'd0);
    check({tag, "_resp_valid"}, {127'b0, resp_valid}, 128'd0);
    check({tag, "_resp_id"}, {126'b0, resp_id}, 128'd0);
    check({tag, "_resp_text"}, resp_text, 128'd0);
    check({tag, "_resp_err"}, {127'b0, resp_err}, 128'd0);
    check({tag, "_core_reset"}, {127'b0, core_reset}, 128'd1);
    check({tag, "_core_decrypt"}, {127'b0, core_decrypt}, 128'd0);
    check({tag, "_core_text"}, core_text, 128'd0);
    check({tag, "_core_key"}, core_key, 128'd0);
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Single requester 2 with the FIPS-197 C.1 vector
    set_req(2, CT, KEY);
    expect_grant(1'b1);
    expect_resp(0);

    // All four continuously valid: strict rotation, wrapping 3 -> 0
    for (int i = 0; i < N_REQ; i++)
      set_req(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    for (int j = 0; j < 5; j++) begin
      expect_grant(1'b0);
      if (j == 4) req_valid = '0;
      expect_resp(0);
    end

    // Consumer stalls 20 cycles while another requester waits
    set_req(0, 128'h0123456789abcdef0011223344556677, 128'hfedcba98765432100f0e0d0c0b0a0908);
    set_req(3, 128'hdeadbeefcafef00d1122334455667788, 128'h8899aabbccddeeff0011223344556677);
    expect_grant(1'b1);
    expect_resp(20);
    expect_grant(1'b1);
    expect_resp(0);

    // Core never finishes: timeout error, then a normal job
    stuck = 1'b1;
    set_req(1, 128'h1111, 128'h2222);
    expect_grant(1'b1);
    expect_resp(0);
    stuck = 1'b0;
    set_req(3, CT, KEY);
    expect_grant(1'b1);
    expect_resp(0);

    // Done on the last WAIT cycle wins; one cycle later is a timeout
    lat = TIMEOUT - 1;
    set_req(2, 128'habcd, 128'h1234);
    expect_grant(1'b1);
    expect_resp(0);
    lat = TIMEOUT;
    set_req(0, 128'h5678, 128'h9abc);
    expect_grant(1'b1);
    expect_resp(0);
    lat = 42;

    // Stale done from the previous job must not cut the next job short
    sticky = 1'b1;
    set_req(0, CT, KEY);
    expect_grant(1'b1);
    expect_resp(0);
    set_req(1, 128'h00ff00ff00ff00ff00ff00ff00ff00ff, 128'h13579bdf2468ace013579bdf2468ace0);
    expect_grant(1'b1);
    expect_resp(0);
    sticky = 1'b0;

    // Reset during WAIT: outputs return to reset values, req 0 wins afterwards
    set_req(1, 128'h77, 128'h88);
    expect_grant(1'b1);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_core_reset", {127'b0, core_reset}, 128'd1);
    check("midrst_resp_valid", {127'b0, resp_valid}, 128'd0);
    check("midrst_req_ready", {124'b0, req_ready}, 128'd0);
    sb.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, 128'(i + 100), 128'(i + 200));
    repeat (2) @(negedge clock);
    check_reset_vals("midrst");
    reset_n = 1'b1;
    exp_ptr = N_REQ - 1;
    expect_grant(1'b1);
    req_valid = '0;
    expect_resp(0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
